// File: rtl/mcu_subsys_bus.sv
// Interconnect from the CPU native memory port to ROM, RAM and the peripheral window.
// Unmapped, ROM-write and timed-out accesses are terminated with an error response.
module mcu_subsys_bus #(
    parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
    parameter logic [31:0] RAM_BASE       = 32'h0001_0000,
    parameter logic [31:0] PER_BASE       = 32'h1000_0000,
    parameter int          REGION_BITS    = 16,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_mem_valid,
    output logic        cpu_mem_ready,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic [31:0] cpu_mem_rdata,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        rom_valid,
    input  logic        rom_ready,
    input  logic [31:0] rom_rdata,
    output logic        ram_valid,
    input  logic        ram_ready,
    input  logic [31:0] ram_rdata,
    output logic        per_valid,
    input  logic        per_ready,
    input  logic [31:0] per_rdata,
    output logic        bus_err,
    output logic [31:0] err_addr,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Last counter value before abort; the abort edge is where it would reach TIMEOUT_CYCLES.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [2:0]  valid_q;          // one-hot {per, ram, rom}, doubles as the registered select
    logic [7:0]  tmo_q;
    logic [31:0] rdata_q;
    logic [31:0] s_addr_q;
    logic [31:0] s_wdata_q;
    logic [3:0]  s_wstrb_q;
    logic        ready_q;
    logic        bus_err_q;
    logic [31:0] err_addr_q;
    logic [7:0]  err_count_q;
    logic [7:0]  err_count_d;

    logic        rom_hit_s;
    logic        ram_hit_s;
    logic        per_hit_s;
    logic        rom_wr_s;
    logic        sel_ready_s;
    logic [31:0] sel_rdata_s;

    function automatic logic region_hit(input logic [31:0] addr, input logic [31:0] base);
        return (((addr ^ base) >> REGION_BITS) == 32'd0);
    endfunction

    // Address decode of the live CPU request.
    always_comb begin
        rom_hit_s = region_hit(cpu_mem_addr, ROM_BASE);
        ram_hit_s = region_hit(cpu_mem_addr, RAM_BASE);
        per_hit_s = region_hit(cpu_mem_addr, PER_BASE);
        rom_wr_s  = rom_hit_s && (cpu_mem_wstrb != 4'd0);
    end

    // Response mux driven only by the registered select; other slaves are ignored.
    always_comb begin
        sel_ready_s = 1'b0;
        sel_rdata_s = 32'd0;
        case (valid_q)
            3'b001: begin
                sel_ready_s = rom_ready;
                sel_rdata_s = rom_rdata;
            end
            3'b010: begin
                sel_ready_s = ram_ready;
                sel_rdata_s = ram_rdata;
            end
            3'b100: begin
                sel_ready_s = per_ready;
                sel_rdata_s = per_rdata;
            end
            default: begin
                sel_ready_s = 1'b0;
                sel_rdata_s = 32'd0;
            end
        endcase
    end

    // Saturating error counter increment.
    always_comb begin
        if (err_count_q == 8'hFF) begin
            err_count_d = 8'hFF;
        end else begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Transaction FSM with registered slave requests and CPU response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            valid_q     <= 3'b000;
            tmo_q       <= 8'd0;
            rdata_q     <= 32'd0;
            s_addr_q    <= 32'd0;
            s_wdata_q   <= 32'd0;
            s_wstrb_q   <= 4'd0;
            ready_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            err_addr_q  <= 32'd0;
            err_count_q <= 8'd0;
        end else begin
            ready_q   <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_mem_valid) begin
                        s_addr_q  <= cpu_mem_addr;
                        s_wdata_q <= cpu_mem_wdata;
                        s_wstrb_q <= cpu_mem_wstrb;
                        tmo_q     <= 8'd0;
                        if ((rom_hit_s && !rom_wr_s) || ram_hit_s || per_hit_s) begin
                            valid_q <= {per_hit_s, ram_hit_s, rom_hit_s};
                            state_q <= ST_ACCESS;
                        end else begin
                            valid_q     <= 3'b000;
                            rdata_q     <= ERR_RDATA;
                            ready_q     <= 1'b1;
                            bus_err_q   <= 1'b1;
                            err_addr_q  <= cpu_mem_addr;
                            err_count_q <= err_count_d;
                            state_q     <= ST_DONE;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // A ready in the abort cycle takes priority over the timeout.
                    if (sel_ready_s) begin
                        valid_q <= 3'b000;
                        rdata_q <= sel_rdata_s;
                        ready_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (tmo_q == TMO_LAST) begin
                        valid_q     <= 3'b000;
                        rdata_q     <= ERR_RDATA;
                        ready_q     <= 1'b1;
                        bus_err_q   <= 1'b1;
                        err_addr_q  <= s_addr_q;
                        err_count_q <= err_count_d;
                        state_q     <= ST_DONE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    valid_q <= 3'b000;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_valid     = valid_q[0];
    assign ram_valid     = valid_q[1];
    assign per_valid     = valid_q[2];
    assign cpu_mem_ready = ready_q;
    assign cpu_mem_rdata = rdata_q;
    assign s_addr        = s_addr_q;
    assign s_wdata       = s_wdata_q;
    assign s_wstrb       = s_wstrb_q;
    assign bus_err       = bus_err_q;
    assign err_addr      = err_addr_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_mcu_subsys_bus.sv
// Directed testbench for mcu_subsys_bus with hand-computed expectations.
module tb_mcu_subsys_bus;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_mem_valid;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_addr;
    logic [31:0] cpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb;
    logic [31:0] cpu_mem_rdata;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        rom_valid, rom_ready;
    logic [31:0] rom_rdata;
    logic        ram_valid, ram_ready;
    logic [31:0] ram_rdata;
    logic        per_valid, per_ready;
    logic [31:0] per_rdata;
    logic        bus_err;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;

    mcu_subsys_bus dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_mem_valid (cpu_mem_valid),
        .cpu_mem_ready (cpu_mem_ready),
        .cpu_mem_addr  (cpu_mem_addr),
        .cpu_mem_wdata (cpu_mem_wdata),
        .cpu_mem_wstrb (cpu_mem_wstrb),
        .cpu_mem_rdata (cpu_mem_rdata),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .s_wstrb       (s_wstrb),
        .rom_valid     (rom_valid),
        .rom_ready     (rom_ready),
        .rom_rdata     (rom_rdata),
        .ram_valid     (ram_valid),
        .ram_ready     (ram_ready),
        .ram_rdata     (ram_rdata),
        .per_valid     (per_valid),
        .per_ready     (per_ready),
        .per_rdata     (per_rdata),
        .bus_err       (bus_err),
        .err_addr      (err_addr),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = addr;
        cpu_mem_wdata = wdata;
        cpu_mem_wstrb = wstrb;
    endtask

    task automatic chk_valids(input string tag, input logic [2:0] exp);
        chk(tag, 32'({per_valid, ram_valid, rom_valid}), 32'(exp));
    endtask

    initial begin
        int n;
        int ready_seen;
        int exp_cnt;

        rst_n         = 1'b0;
        cpu_mem_valid = 1'b0;
        cpu_mem_addr  = 32'd0;
        cpu_mem_wdata = 32'd0;
        cpu_mem_wstrb = 4'd0;
        rom_ready     = 1'b1;
        rom_rdata     = 32'h0000_0013;
        ram_ready     = 1'b0;
        ram_rdata     = 32'h1234_5678;
        per_ready     = 1'b0;
        per_rdata     = 32'hA5A5_0001;

        tick();
        tick();
        chk_valids("rst_valids", 3'b000);
        chk("rst_ready", 32'(cpu_mem_ready), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_rdata", cpu_mem_rdata, 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_err_cnt", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // ROM read, zero-wait
        req(32'h0000_0100, 32'd0, 4'd0);
        tick();
        chk_valids("rom_acc_valids", 3'b001);
        chk("rom_acc_ready", 32'(cpu_mem_ready), 32'd0);
        chk("rom_acc_saddr", s_addr, 32'h0000_0100);
        tick();
        chk("rom_done_ready", 32'(cpu_mem_ready), 32'd1);
        chk("rom_done_rdata", cpu_mem_rdata, 32'h0000_0013);
        chk_valids("rom_done_valids", 3'b000);
        chk("rom_done_err", 32'(bus_err), 32'd0);
        cpu_mem_valid = 1'b0;
        tick();
        chk("rom_idle_ready", 32'(cpu_mem_ready), 32'd0);
        chk("rom_idle_rdata_hold", cpu_mem_rdata, 32'h0000_0013);

        // RAM write, ready delayed to the 6th ACCESS cycle; CPU bus scrambled meanwhile
        req(32'h0001_0040, 32'hCAFE_F00D, 4'b0011);
        tick();
        cpu_mem_addr  = 32'h5555_AAAA;
        cpu_mem_wdata = 32'h0BAD_0BAD;
        cpu_mem_wstrb = 4'b1100;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) ram_ready = 1'b1;
            chk_valids("ram_acc_valids", 3'b010);
            chk("ram_acc_saddr", s_addr, 32'h0001_0040);
            chk("ram_acc_swdata", s_wdata, 32'hCAFE_F00D);
            chk("ram_acc_swstrb", 32'(s_wstrb), 32'h3);
            chk("ram_acc_ready", 32'(cpu_mem_ready), 32'd0);
            tick();
        end
        chk_valids("ram_done_valids", 3'b000);
        chk("ram_done_ready", 32'(cpu_mem_ready), 32'd1);
        chk("ram_done_rdata", cpu_mem_rdata, 32'h1234_5678);
        chk("ram_done_err", 32'(bus_err), 32'd0);
        cpu_mem_valid = 1'b0;
        ram_ready     = 1'b0;
        tick();
        chk("ram_idle_ready", 32'(cpu_mem_ready), 32'd0);

        // Unmapped read
        req(32'h2000_0000, 32'd0, 4'd0);
        tick();
        chk("unm_ready", 32'(cpu_mem_ready), 32'd1);
        chk("unm_rdata", cpu_mem_rdata, 32'hDEAD_BEEF);
        chk("unm_bus_err", 32'(bus_err), 32'd1);
        chk_valids("unm_valids", 3'b000);
        chk("unm_err_cnt", 32'(err_count), 32'd1);
        cpu_mem_valid = 1'b0;
        tick();
        chk("unm_idle_err", 32'(bus_err), 32'd0);

        // Write to ROM
        req(32'h0000_0004, 32'h1111_2222, 4'hF);
        tick();
        chk("romwr_ready", 32'(cpu_mem_ready), 32'd1);
        chk("romwr_rdata", cpu_mem_rdata, 32'hDEAD_BEEF);
        chk_valids("romwr_valids", 3'b000);
        chk("romwr_err_cnt", 32'(err_count), 32'd2);
        chk("romwr_err_addr", err_addr, 32'h0000_0004);
        cpu_mem_valid = 1'b0;
        tick();

        // Peripheral hang -> timeout
        req(32'h1000_0008, 32'd0, 4'd0);
        tick();
        n = 0;
        ready_seen = 0;
        while (per_valid && n < 300) begin
            if (cpu_mem_ready) ready_seen++;
            n++;
            tick();
        end
        chk("hang_valid_cycles", 32'(n), 32'd255);
        chk("hang_no_early_ready", 32'(ready_seen), 32'd0);
        chk("hang_ready", 32'(cpu_mem_ready), 32'd1);
        chk("hang_rdata", cpu_mem_rdata, 32'hDEAD_BEEF);
        chk("hang_bus_err", 32'(bus_err), 32'd1);
        chk("hang_err_cnt", 32'(err_count), 32'd3);
        chk("hang_err_addr", err_addr, 32'h1000_0008);
        cpu_mem_valid = 1'b0;
        tick();

        // Ready arrives in the abort cycle -> normal completion
        req(32'h1000_0010, 32'd0, 4'd0);
        tick();
        for (int i = 1; i <= 254; i++) tick();
        chk_valids("race_last_valids", 3'b100);
        per_ready = 1'b1;
        tick();
        chk("race_ready", 32'(cpu_mem_ready), 32'd1);
        chk("race_rdata", cpu_mem_rdata, 32'hA5A5_0001);
        chk("race_bus_err", 32'(bus_err), 32'd0);
        chk("race_err_cnt", 32'(err_count), 32'd3);
        per_ready     = 1'b0;
        cpu_mem_valid = 1'b0;
        tick();

        // Reset during a stalled RAM read
        req(32'h0001_0000, 32'd0, 4'd0);
        tick();
        tick();
        tick();
        chk_valids("rstmid_pre_valids", 3'b010);
        rst_n         = 1'b0;
        cpu_mem_valid = 1'b0;
        tick();
        chk_valids("rstmid_valids", 3'b000);
        chk("rstmid_ready", 32'(cpu_mem_ready), 32'd0);
        chk("rstmid_err_cnt", 32'(err_count), 32'd0);
        chk("rstmid_err_addr", err_addr, 32'd0);
        chk("rstmid_rdata", cpu_mem_rdata, 32'd0);
        rst_n = 1'b1;
        tick();
        chk_valids("rstmid_idle_valids", 3'b000);

        // 256 forced errors -> counter saturates
        for (int k = 0; k < 256; k++) begin
            req(32'h3000_0000 + 32'(k * 4), 32'd0, 4'd0);
            tick();
            if (k == 0 || k >= 254) begin
                exp_cnt = (k + 1 > 255) ? 255 : k + 1;
                chk("sat_ready", 32'(cpu_mem_ready), 32'd1);
                chk("sat_err_cnt", 32'(err_count), 32'(exp_cnt));
            end
            cpu_mem_valid = 1'b0;
            tick();
        end
        chk("sat_err_addr", err_addr, 32'h3000_03FC);
        chk("sat_final_cnt", 32'(err_count), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
